seg_bcd_converter: RTL and testbench

SEG_BCD_CONVERTER -- requirements
Module: seg_bcd_converter

---
 rtl/seg_pkg.sv | 47 ++++
 rtl/seg_bcd_converter_digit_adj.sv | 19 +
 rtl/seg_bcd_converter.sv | 164 ++++++++++++++++
 tb/tb_seg_bcd_converter.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared definitions for the segment-display block: BCD converter sizing,
// converter FSM encoding, and seven-segment glyph encoding.
// No ports (package). Converter options: SEG_BCD_SIGNED_EN enables signed mode.
package seg_pkg;

    // Converter sizing
    localparam int unsigned DATA_W = 32;
    localparam int unsigned DIGITS = 8;
    localparam int unsigned BCD_W  = 40;
    localparam int unsigned ITER   = 32;
    localparam int unsigned CNT_W  = 6;
    localparam int unsigned NIB_W  = 4;
    localparam int unsigned ADJ_N  = BCD_W / NIB_W;

    // Converter FSM encoding
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } conv_state_e;

    // Seven-segment display definitions, segment order {g,f,e,d,c,b,a}, active high
    localparam int unsigned SEG_W = 7;
    typedef logic [SEG_W-1:0] seg_t;

    localparam seg_t SEG_BLANK = 7'b000_0000;
    localparam seg_t SEG_MINUS = 7'b100_0000;

    function automatic seg_t bcd_to_seg(input logic [NIB_W-1:0] nib);
        seg_t seg;
        case (nib)
            4'd0:    seg = 7'b011_1111;
            4'd1:    seg = 7'b000_0110;
            4'd2:    seg = 7'b101_1011;
            4'd3:    seg = 7'b100_1111;
            4'd4:    seg = 7'b110_0110;
            4'd5:    seg = 7'b110_1101;
            4'd6:    seg = 7'b111_1101;
            4'd7:    seg = 7'b000_0111;
            4'd8:    seg = 7'b111_1111;
            4'd9:    seg = 7'b110_1111;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seg_bcd_converter_digit_adj.sv
// bcd_digit_adj: double-dabble nibble correction (add 3 when nibble >= 5).
// Ports:
//   nib_i  - BCD nibble before the shift
//   nib_o  - corrected nibble
module bcd_digit_adj
    import seg_pkg::*;
(
    input  logic [NIB_W-1:0] nib_i,
    output logic [NIB_W-1:0] nib_o
);

    always_comb begin
        nib_o = nib_i;
        if (nib_i >= NIB_W'(5)) begin
            nib_o = nib_i + NIB_W'(3);
        end
    end

endmodule

// File: rtl/seg_bcd_converter.sv
// seg_bcd_converter: sequential double-dabble binary-to-BCD converter.
// A start accepted in IDLE loads the operand; 32 shift iterations follow,
// then the DONE state publishes the result with a one-cycle done pulse.
// Ports:
//   clk      - system clock, rising edge
//   rst      - asynchronous active-high reset
//   start    - conversion request, sampled only in IDLE
//   bin_in   - binary operand, captured on the accepting edge
//   busy     - high while not IDLE
//   done     - one-cycle completion pulse
//   digits   - eight BCD digits, [31:28] most significant
//   overflow - result exceeds eight decimal digits
//   neg      - sign of the operand (signed build only, otherwise 0)
// Build option: define SEG_BCD_SIGNED_EN to convert the two's-complement
// magnitude and report the sign on neg.
module seg_bcd_converter
    import seg_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] bin_in,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] digits,
    output logic              overflow,
    output logic              neg
);

    conv_state_e       state_q, state_d;
    logic [DATA_W-1:0] op_q, op_d;
    logic [BCD_W-1:0]  acc_q, acc_d;
    logic [BCD_W-1:0]  acc_adj;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [DATA_W-1:0] digits_q, digits_d;
    logic              ovf_q, ovf_d;

    logic              accept;
    logic              last_iter;

    assign accept    = (state_q == ST_IDLE) && start;
    assign last_iter = (cnt_q == CNT_W'(ITER - 1));

    // Per-digit add-3 correction applied ahead of each shift
    for (genvar g = 0; g < ADJ_N; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .nib_i (acc_q[g*NIB_W +: NIB_W]),
            .nib_o (acc_adj[g*NIB_W +: NIB_W])
        );
    end

    // Operand load value, sign capture
`ifdef SEG_BCD_SIGNED_EN
    logic              sign_q, sign_d;
    logic              neg_q, neg_d;
    logic [DATA_W-1:0] load_val;

    // Magnitude; 0x80000000 negates to itself, which is the correct unsigned magnitude
    assign load_val = bin_in[DATA_W-1] ? DATA_W'(~bin_in + DATA_W'(1)) : bin_in;
    assign neg      = neg_q;
`else
    logic [DATA_W-1:0] load_val;

    assign load_val = bin_in;
    assign neg      = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start) state_d = ST_SHIFT;
            ST_SHIFT: if (last_iter) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Output logic: results only change on leaving DONE
    always_comb begin
        busy_d   = (state_d != ST_IDLE);
        done_d   = 1'b0;
        digits_d = digits_q;
        ovf_d    = ovf_q;
        if (state_q == ST_DONE) begin
            done_d   = 1'b1;
            digits_d = acc_q[DATA_W-1:0];
            ovf_d    = |acc_q[BCD_W-1:DATA_W];
        end
    end

    // Datapath next values: load on accept, adjust-and-shift in SHIFT
    always_comb begin
        op_d  = op_q;
        acc_d = acc_q;
        cnt_d = cnt_q;
        if (accept) begin
            op_d  = load_val;
            acc_d = '0;
            cnt_d = '0;
        end else if (state_q == ST_SHIFT) begin
            acc_d = {acc_adj[BCD_W-2:0], op_q[DATA_W-1]};
            op_d  = {op_q[DATA_W-2:0], 1'b0};
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q     <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            digits_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            op_q     <= op_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            digits_q <= digits_d;
            ovf_q    <= ovf_d;
        end
    end

`ifdef SEG_BCD_SIGNED_EN
    // Sign is captured with the operand and published with the result
    always_comb begin
        sign_d = accept ? bin_in[DATA_W-1] : sign_q;
        neg_d  = (state_q == ST_DONE) ? sign_q : neg_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sign_q <= 1'b0;
            neg_q  <= 1'b0;
        end else begin
            sign_q <= sign_d;
            neg_q  <= neg_d;
        end
    end
`endif

    assign busy     = busy_q;
    assign done     = done_q;
    assign digits   = digits_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_seg_bcd_converter.sv
// Directed self-checking bench for seg_bcd_converter.
module tb_seg_bcd_converter;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] bin_in;
    logic        busy;
    logic        done;
    logic [31:0] digits;
    logic        overflow;
    logic        neg;

    int errors = 0;
    int checks = 0;

    seg_bcd_converter dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .bin_in   (bin_in),
        .busy     (busy),
        .done     (done),
        .digits   (digits),
        .overflow (overflow),
        .neg      (neg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one request (called #1 after a rising edge) and wait for done.
    // lat counts edges after the accepting edge; bcnt counts busy-high samples.
    task automatic run_conv(input logic [31:0] v, output int lat, output int bcnt);
        bin_in = v;
        start  = 1'b1;
        @(posedge clk); #1;
        start  = 1'b0;
        lat    = 0;
        bcnt   = busy ? 1 : 0;
        while (!done && lat < 45) begin
            @(posedge clk); #1;
            lat++;
            if (busy) bcnt++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; bin_in = '0;
        #12;
        checks++;
        if ({busy, done, digits, overflow, neg} !== 35'd0) begin
            errors++;
            $display("FAIL reset_outputs: busy=%b done=%b digits=%h ovf=%b neg=%b, need all 0",
                     busy, done, digits, overflow, neg);
        end
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_zero;
        int lat, bcnt;
        run_conv(32'd0, lat, bcnt);
        checks++;
        if (lat !== 33) begin
            errors++; $display("FAIL zero_latency: got %0d need 33", lat);
        end
        checks++;
        if (digits !== 32'h0000_0000 || overflow !== 1'b0) begin
            errors++; $display("FAIL zero_result: digits=%h ovf=%b need 00000000/0", digits, overflow);
        end
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0) begin
            errors++; $display("FAIL zero_done_width: done=%b one cycle after pulse, need 0", done);
        end
    endtask

    task automatic test_mid_value;
        int lat, bcnt;
        run_conv(32'd12345678, lat, bcnt);
        checks++;
        if (digits !== 32'h1234_5678 || overflow !== 1'b0 || neg !== 1'b0) begin
            errors++; $display("FAIL mid_result: digits=%h ovf=%b neg=%b need 12345678/0/0",
                               digits, overflow, neg);
        end
        checks++;
        if (bcnt !== 33) begin
            errors++; $display("FAIL mid_busy_cycles: got %0d need 33", bcnt);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL mid_busy_at_done: busy=%b need 0", busy);
        end
    endtask

    task automatic test_all_ones;
        int lat, bcnt;
        run_conv(32'hFFFF_FFFF, lat, bcnt);
`ifdef SEG_BCD_SIGNED_EN
        checks++;
        if (digits !== 32'h0000_0001 || overflow !== 1'b0 || neg !== 1'b1) begin
            errors++; $display("FAIL ones_signed: digits=%h ovf=%b neg=%b need 00000001/0/1",
                               digits, overflow, neg);
        end
        run_conv(32'h8000_0000, lat, bcnt);
        checks++;
        if (digits !== 32'h4748_3648 || overflow !== 1'b1 || neg !== 1'b1) begin
            errors++; $display("FAIL min_signed: digits=%h ovf=%b neg=%b need 47483648/1/1",
                               digits, overflow, neg);
        end
`else
        checks++;
        if (digits !== 32'h9496_7295 || overflow !== 1'b1 || neg !== 1'b0) begin
            errors++; $display("FAIL ones_unsigned: digits=%h ovf=%b neg=%b need 94967295/1/0",
                               digits, overflow, neg);
        end
`endif
        // Overflow must clear on the next in-range result
        run_conv(32'd99999999, lat, bcnt);
        checks++;
        if (digits !== 32'h9999_9999 || overflow !== 1'b0) begin
            errors++; $display("FAIL max8_result: digits=%h ovf=%b need 99999999/0", digits, overflow);
        end
    endtask

    task automatic test_back_to_back;
        int dones = 0;
        int cyc   = 0;
        bin_in = 32'd1000;
        start  = 1'b1;
        @(posedge clk); #1;               // E0
        start = 1'b0;
        repeat (5) begin @(posedge clk); #1; cyc++; end
        bin_in = 32'd7;                   // second request mid-conversion
        start  = 1'b1;
        @(posedge clk); #1; cyc++;
        start  = 1'b0;
        // Raise start again across the DONE-state edge (E33)
        while (cyc < 32) begin @(posedge clk); #1; cyc++; end
        start = 1'b1;
        @(posedge clk); #1; cyc++;        // E33
        start = 1'b0;
        if (done) dones++;
        checks++;
        if (digits !== 32'h0000_1000 || done !== 1'b1) begin
            errors++; $display("FAIL b2b_result: digits=%h done=%b need 00001000/1", digits, done);
        end
        repeat (40) begin
            @(posedge clk); #1;
            if (done) dones++;
        end
        checks++;
        if (dones !== 1) begin
            errors++; $display("FAIL b2b_done_count: got %0d pulses need 1", dones);
        end
        checks++;
        if (busy !== 1'b0 || digits !== 32'h0000_1000) begin
            errors++; $display("FAIL b2b_no_queue: busy=%b digits=%h need 0/00001000", busy, digits);
        end
    endtask

    task automatic test_reset_abort;
        int lat, bcnt;
        int dones = 0;
        run_conv(32'd42, lat, bcnt);
        checks++;
        if (digits !== 32'h0000_0042) begin
            errors++; $display("FAIL abort_prev: digits=%h need 00000042", digits);
        end
        @(posedge clk); #1;
        bin_in = 32'd999;
        start  = 1'b1;
        @(posedge clk); #1;               // E0
        start = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || digits !== 32'h0 || done !== 1'b0 || overflow !== 1'b0) begin
            errors++; $display("FAIL abort_async: busy=%b digits=%h done=%b ovf=%b need 0/0/0/0",
                               busy, digits, done, overflow);
        end
        @(negedge clk); rst = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) dones++;
        end
        checks++;
        if (dones !== 0 || digits !== 32'h0) begin
            errors++; $display("FAIL abort_no_done: pulses=%0d digits=%h need 0/00000000", dones, digits);
        end
        run_conv(32'd87654321, lat, bcnt);
        checks++;
        if (digits !== 32'h8765_4321 || lat !== 33) begin
            errors++; $display("FAIL abort_recover: digits=%h lat=%0d need 87654321/33", digits, lat);
        end
    endtask

    task automatic test_first_edge_after_reset;
        int lat, bcnt;
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        #1;
        run_conv(32'd5, lat, bcnt);
        checks++;
        if (digits !== 32'h0000_0005 || lat !== 33) begin
            errors++; $display("FAIL post_reset_start: digits=%h lat=%0d need 00000005/33", digits, lat);
        end
    endtask

    initial begin
        test_reset();
        test_zero();
        test_mid_value();
        test_all_ones();
        test_back_to_back();
        test_reset_abort();
        test_first_edge_after_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
